// File: rtl/segment_if.sv
// segment_if: seven-segment display bus and the decoder's monitor outputs
interface segment_if;
    logic [6:0] segment;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_strobe;
    logic       step_up;
    logic       step_down;
    logic       jump;
    logic       invalid;
    logic [7:0] err_count;
    modport master (
        output segment,
        input  digit, digit_valid, digit_strobe, step_up, step_down, jump, invalid, err_count
    );
    modport slave (
        input  segment,
        output digit, digit_valid, digit_strobe, step_up, step_down, jump, invalid, err_count
    );
endinterface

// File: rtl/segment_decoder.sv
// segment_decoder: debounces the segment bus, decodes it to a BCD digit and classifies each change
module segment_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input logic      clk,
    input logic      rst,
    segment_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] SMAX = CW'(STABLE_CYCLES);
    typedef enum logic {EMPTY, HAVE_DIGIT} state_t;
    state_t state, state_n;
    logic [6:0] seg_in, seg_q, acc;
    logic [CW-1:0] cnt;
    logic [3:0] val, up_d, dn_d;
    logic legal, blank, accept, up_n, dn_n, jp_n;
    assign seg_in = ACTIVE_LOW ? ~bus.segment : bus.segment;
    assign blank  = seg_q == 7'h00;
    assign accept = cnt == SMAX && seg_q != acc;
    assign up_d   = bus.digit == 4'd9 ? 4'd0 : bus.digit + 4'd1;
    assign dn_d   = bus.digit == 4'd0 ? 4'd9 : bus.digit - 4'd1;
    always_comb begin
        legal = 1'b1;
        val   = 4'd0;
        case (seg_q)
            7'h3F: val = 4'd0;
            7'h06: val = 4'd1;
            7'h5B: val = 4'd2;
            7'h4F: val = 4'd3;
            7'h66: val = 4'd4;
            7'h6D: val = 4'd5;
            7'h7D: val = 4'd6;
            7'h07: val = 4'd7;
            7'h7F: val = 4'd8;
            7'h6F: val = 4'd9;
            default: legal = 1'b0;
        endcase
    end
    always_comb begin
        state_n = state;
        up_n    = 1'b0;
        dn_n    = 1'b0;
        jp_n    = 1'b0;
        if (accept) begin
            state_n = legal ? HAVE_DIGIT : EMPTY;
            if (legal && state == HAVE_DIGIT) begin
                up_n = val == up_d;
                dn_n = val == dn_d;
                jp_n = !(val == up_d) && !(val == dn_d);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= EMPTY;
            seg_q            <= '0;
            acc              <= '0;
            cnt              <= '0;
            bus.digit        <= '0;
            bus.digit_valid  <= 1'b0;
            bus.digit_strobe <= 1'b0;
            bus.step_up      <= 1'b0;
            bus.step_down    <= 1'b0;
            bus.jump         <= 1'b0;
            bus.invalid      <= 1'b0;
            bus.err_count    <= '0;
        end else begin
            state            <= state_n;
            seg_q            <= seg_in;
            cnt              <= seg_in != seg_q ? CW'(1) : (cnt == SMAX ? cnt : cnt + CW'(1));
            bus.digit_strobe <= accept;
            bus.step_up      <= up_n;
            bus.step_down    <= dn_n;
            bus.jump         <= jp_n;
            if (accept) begin
                acc             <= seg_q;
                bus.digit       <= legal ? val : bus.digit;
                bus.digit_valid <= legal;
                bus.invalid     <= !legal && !blank;
                bus.err_count   <= (!legal && !blank && bus.err_count != 8'hFF) ? bus.err_count + 8'd1 : bus.err_count;
            end
        end
    end
endmodule

// File: tb/tb_segment_decoder.sv
// tb_segment_decoder: directed stimulus with a scoreboard of expected strobes on three decoder variants
module tb_segment_decoder;
    typedef struct packed {
        logic [3:0] d;
        logic       v, up, dn, jp, inv;
        logic [7:0] err;
    } out_t;
    typedef struct {
        int   id;
        int   cyc;
        out_t o;
    } ent_t;
    logic clk = 1'b0, rst = 1'b1;
    int cyc = 0, checks = 0, failures = 0;
    logic [6:0] pat_in[3];
    out_t obs[3];
    logic stb[3];
    ent_t q[$];
    ent_t e;
    logic [6:0] m_acc[3];
    logic       m_have[3];
    logic [3:0] m_d[3];
    logic [7:0] m_err[3];
    int         sc[3] = '{4, 1, 4};
    logic [6:0] tbl[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    segment_if s0 ();
    segment_if s1 ();
    segment_if s2 ();
    segment_decoder #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b0)) u0 (.clk(clk), .rst(rst), .bus(s0.slave));
    segment_decoder #(.STABLE_CYCLES(1), .ACTIVE_LOW(1'b0)) u1 (.clk(clk), .rst(rst), .bus(s1.slave));
    segment_decoder #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) u2 (.clk(clk), .rst(rst), .bus(s2.slave));
    assign s0.segment = pat_in[0];
    assign s1.segment = pat_in[1];
    assign s2.segment = ~pat_in[2];
    assign obs[0] = {s0.digit, s0.digit_valid, s0.step_up, s0.step_down, s0.jump, s0.invalid, s0.err_count};
    assign obs[1] = {s1.digit, s1.digit_valid, s1.step_up, s1.step_down, s1.jump, s1.invalid, s1.err_count};
    assign obs[2] = {s2.digit, s2.digit_valid, s2.step_up, s2.step_down, s2.jump, s2.invalid, s2.err_count};
    assign stb[0] = s0.digit_strobe;
    assign stb[1] = s1.digit_strobe;
    assign stb[2] = s2.digit_strobe;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Expected outcome of accepting pat on decoder id, observed S+1 cycles after driving
    task automatic expect_pat(input int id, input logic [6:0] pat);
        ent_t n;
        int val = -1;
        for (int i = 0; i < 10; i++) if (tbl[i] == pat) val = i;
        n.id = id;
        n.cyc = cyc + 1 + sc[id];
        n.o = '0;
        if (val >= 0) begin
            if (m_have[id]) begin
                n.o.up = val == (m_d[id] == 9 ? 0 : int'(m_d[id]) + 1);
                n.o.dn = val == (m_d[id] == 0 ? 9 : int'(m_d[id]) - 1);
                n.o.jp = !n.o.up && !n.o.dn;
            end
            m_d[id] = 4'(val);
            m_have[id] = 1'b1;
            n.o.v = 1'b1;
        end else begin
            m_have[id] = 1'b0;
            if (pat != 7'h00) begin
                n.o.inv = 1'b1;
                if (m_err[id] != 8'hFF) m_err[id] = m_err[id] + 8'd1;
            end
        end
        n.o.d = m_d[id];
        n.o.err = m_err[id];
        m_acc[id] = pat;
        q.push_back(n);
    endtask
    task automatic drive(input int id, input logic [6:0] pat, input int n);
        pat_in[id] = pat;
        if (n >= sc[id] && pat != m_acc[id]) expect_pat(id, pat);
        repeat (n) @(negedge clk);
    endtask
    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = '0;
            m_have[i] = 1'b0;
            m_d[i] = '0;
            m_err[i] = '0;
        end
    endtask
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            chk($sformatf("missing_strobe_dut%0d", e.id), 32'(cyc), 32'(e.cyc));
        end
        for (int i = 0; i < 3; i++) if (stb[i]) begin
            if (q.size() == 0 || q[0].id != i) chk($sformatf("unexpected_strobe_dut%0d", i), 32'(stb[i]), 32'd0);
            else begin
                e = q.pop_front();
                chk($sformatf("strobe_cycle_dut%0d", i), 32'(cyc), 32'(e.cyc));
                chk($sformatf("strobe_outputs_dut%0d", i), 32'(obs[i]), 32'(e.o));
            end
        end
    end
    initial begin
        pat_in = '{7'h00, 7'h00, 7'h00};
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", 32'(obs[0]), 32'd0);
        chk("reset_strobe", 32'(stb[0]), 32'd0);
        drive(0, 7'h3F, 6);
        drive(0, 7'h06, 6);
        drive(0, 7'h5B, 6);
        chk("digit_after_steps", 32'(s0.digit), 32'd2);
        drive(0, 7'h06, 6);
        drive(0, 7'h6F, 6);
        drive(0, 7'h3F, 6);
        drive(0, 7'h6F, 6);
        drive(0, 7'h3F, 6);
        drive(0, 7'h66, 6);
        drive(0, 7'h06, 6);
        drive(0, 7'h5B, 2);
        drive(0, 7'h06, 8);
        chk("glitch_digit_holds", 32'(s0.digit), 32'd1);
        drive(1, 7'h06, 3);
        drive(1, 7'h5B, 2);
        drive(1, 7'h06, 3);
        drive(0, 7'h55, 6);
        chk("invalid_level", 32'({s0.invalid, s0.digit_valid, s0.digit}), 32'h21);
        chk("err_count_one", 32'(s0.err_count), 32'd1);
        drive(0, 7'h06, 6);
        for (int i = 0; i < 300; i++) begin
            drive(0, (i % 2 == 0) ? 7'h55 : 7'h7E, 5);
            drive(0, 7'h00, 5);
        end
        chk("err_count_saturated", 32'(s0.err_count), 32'd255);
        drive(2, 7'h3F, 6);
        chk("active_low_digit", 32'({s2.digit_valid, s2.digit}), 32'h10);
        drive(2, 7'h06, 6);
        drive(2, 7'h00, 6);
        drive(1, 7'h00, 3);
        drive(0, 7'h06, 6);
        pat_in[0] = 7'h5B;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) chk($sformatf("midfilter_reset_dut%0d", i), 32'({stb[i], obs[i]}), 32'd0);
        expect_pat(0, 7'h5B);
        @(negedge clk);
        chk("no_strobe_after_release", 32'(stb[0]), 32'd0);
        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
